// File: rtl/ex_stage_mc.sv
// Execute stage: single-cycle ALU ops plus an iterative radix-2 shift-add multiplier,
// with valid/ready intake from ID, register-file writeback and in-flight rd for hazards.
module ex_stage_mc #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [2:0]      alu_op_i,
  input  logic            flush_i,
  output logic            wb_we_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      busy_rd_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [4:0]        r_busy_rd;
  logic              r_wb_we;
  logic [4:0]        r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;

  logic              w_accept;
  logic              w_is_mul;
  logic              w_mul_last;
  logic [XLEN-1:0]   w_acc_nxt;
  logic [XLEN-1:0]   w_alu_res;

  assign w_accept   = valid_i & ready_o & ~flush_i;
  assign w_is_mul   = (alu_op_i == 3'd5);
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == CNT_W'(XLEN-1));
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Single-cycle ALU; reserved encodings produce zero.
  always_comb begin
    w_alu_res = '0;
    case (alu_op_i)
      3'd0:    w_alu_res = rs1_data_i + rs2_data_i;
      3'd1:    w_alu_res = rs1_data_i - rs2_data_i;
      3'd2:    w_alu_res = rs1_data_i & rs2_data_i;
      3'd3:    w_alu_res = rs1_data_i | rs2_data_i;
      3'd4:    w_alu_res = rs1_data_i ^ rs2_data_i;
      default: w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Flush has priority over completion, so a flushed MUL never writes back.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (flush_i || w_mul_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (r_state == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy_rd <= '0;
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_mcand   <= rs1_data_i;
              r_mplier  <= rs2_data_i;
              r_acc     <= '0;
              r_cnt     <= '0;
              r_busy_rd <= rd_addr_i;
            end else begin
              r_wb_data <= w_alu_res;
              r_wb_rd   <= rd_addr_i;
              r_wb_we   <= (rd_addr_i != 5'd0);
            end
          end
        end
        S_MUL: begin
          if (flush_i) begin
            r_busy_rd <= '0;
          end else begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_mul_last) begin
              r_wb_data <= w_acc_nxt;
              r_wb_rd   <= r_busy_rd;
              r_wb_we   <= (r_busy_rd != 5'd0);
              r_busy_rd <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_we_o      = r_wb_we;
  assign wb_rd_addr_o = r_wb_rd;
  assign wb_data_o    = r_wb_data;
  assign busy_rd_o    = r_busy_rd;

endmodule
